// File: rtl/robot_pkg.sv
// Shared encodings for the wheel drive: FSM states, commanded modes and the
// wheel direction pattern each mode needs.
package robot_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_FWD  = 2'd1,
    S_ROT  = 2'd2,
    S_DEAD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    M_STOP = 2'd0,
    M_FWD  = 2'd1,
    M_ROT  = 2'd2
  } mode_e;

  // {left, right}, 1 = forward; rotation is clockwise, away from the left wall
  localparam logic [1:0] DIRS_FWD = 2'b11;
  localparam logic [1:0] DIRS_ROT = 2'b10;

  function automatic mode_e decode_cmd(input logic front, input logic rotate);
    mode_e m;
    case ({front, rotate})
      2'b10:   m = M_FWD;
      2'b01:   m = M_ROT;
      default: m = M_STOP;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] mode_dirs(input mode_e m);
    return (m == M_ROT) ? DIRS_ROT : DIRS_FWD;
  endfunction

  function automatic state_e mode_state(input mode_e m);
    state_e s;
    case (m)
      M_FWD:   s = S_FWD;
      M_ROT:   s = S_ROT;
      default: s = S_STOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM with a shadow duty register that only updates on a period
// boundary, so a duty change never produces a truncated or stretched pulse.
module motor_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty_i,
  input  logic             force_off_i,
  output logic             pwm_o,
  output logic [PWM_W-1:0] duty_act_o
);

  localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] duty_act_q;

  // A zero request bypasses the boundary wait so stopping is never delayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      duty_act_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
      if (duty_i == '0) begin
        duty_act_q <= '0;
      end else if (&cnt_q) begin
        duty_act_q <= duty_i;
      end
    end
  end

  assign pwm_o      = (cnt_q < duty_act_q) && !force_off_i;
  assign duty_act_o = duty_act_q;

endmodule

// File: rtl/robot_motor_drive.sv
// Wheel drive stage: turns front/rotate commands into direction bits and a
// soft-started PWM, with a dead-time interlock around every direction change.
//
//  state  | meaning
//  S_STOP | duty 0, direction bits held, waiting for a move command
//  S_FWD  | both wheels forward, duty ramping toward FWD_DUTY
//  S_ROT  | left forward / right reverse, duty ramping toward ROT_DUTY
//  S_DEAD | PWMs forced low, counting down before the new directions load
module robot_motor_drive
  import robot_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int FWD_DUTY  = 200,
  parameter int ROT_DUTY  = 128,
  parameter int RAMP_STEP = 8,
  parameter int RAMP_DIV  = 256,
  parameter int DEAD_CYC  = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic front,
  input  logic rotate,
  output logic pwm_left,
  output logic pwm_right,
  output logic dir_left,
  output logic dir_right,
  output logic moving,
  output logic cmd_err
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [RAMP_W-1:0] RAMP_LOAD = RAMP_W'(RAMP_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

  localparam logic [PWM_W:0] FWD_T  = (PWM_W+1)'(FWD_DUTY);
  localparam logic [PWM_W:0] ROT_T  = (PWM_W+1)'(ROT_DUTY);
  localparam logic [PWM_W:0] STEP_T = (PWM_W+1)'(RAMP_STEP);

  logic              front_q;
  logic              rotate_q;
  logic              cmd_err_q;
  state_e            state_q;
  logic [PWM_W-1:0]  duty_q;
  logic [RAMP_W-1:0] ramp_cnt_q;
  logic [DEAD_W-1:0] dead_cnt_q;
  logic              dir_l_q;
  logic              dir_r_q;

  mode_e             cmd;
  logic [1:0]        cmd_dirs;
  logic [PWM_W:0]    target;
  logic [PWM_W:0]    duty_sum;
  logic [PWM_W-1:0]  duty_ramp_d;
  logic              ramp_tick;

  logic              pwm;
  logic [PWM_W-1:0]  duty_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_q   <= 1'b0;
      rotate_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      front_q   <= front;
      rotate_q  <= rotate;
      cmd_err_q <= front & rotate;
    end
  end

  // Sum is one bit wider than duty so the ramp saturates instead of wrapping
  always_comb begin
    cmd         = decode_cmd(front_q, rotate_q);
    cmd_dirs    = mode_dirs(cmd);
    target      = (state_q == S_ROT) ? ROT_T : FWD_T;
    duty_sum    = {1'b0, duty_q} + STEP_T;
    duty_ramp_d = (duty_sum > target) ? target[PWM_W-1:0] : duty_sum[PWM_W-1:0];
    ramp_tick   = (ramp_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_STOP;
      duty_q     <= '0;
      ramp_cnt_q <= '0;
      dead_cnt_q <= '0;
      dir_l_q    <= 1'b1;
      dir_r_q    <= 1'b1;
    end else begin
      case (state_q)
        S_STOP: begin
          duty_q <= '0;
          if (cmd != M_STOP) begin
            ramp_cnt_q <= RAMP_LOAD;
            dead_cnt_q <= DEAD_LOAD;
            state_q    <= (cmd_dirs == {dir_l_q, dir_r_q}) ? mode_state(cmd) : S_DEAD;
          end
        end

        S_FWD, S_ROT: begin
          if (cmd == M_STOP) begin
            state_q <= S_STOP;
            duty_q  <= '0;
          end else if (mode_state(cmd) != state_q) begin
            state_q    <= S_DEAD;
            duty_q     <= '0;
            dead_cnt_q <= DEAD_LOAD;
          end else if (ramp_tick) begin
            duty_q     <= duty_ramp_d;
            ramp_cnt_q <= RAMP_LOAD;
          end else begin
            ramp_cnt_q <= ramp_cnt_q - RAMP_ONE;
          end
        end

        // The pending mode is simply the live command: any non-stop command
        // seen here replaces the previous one without restarting the count.
        S_DEAD: begin
          duty_q <= '0;
          if (cmd == M_STOP) begin
            state_q <= S_STOP;
          end else if (dead_cnt_q == '0) begin
            {dir_l_q, dir_r_q} <= cmd_dirs;
            state_q            <= mode_state(cmd);
            ramp_cnt_q         <= RAMP_LOAD;
          end else begin
            dead_cnt_q <= dead_cnt_q - DEAD_ONE;
          end
        end

        default: begin
          state_q <= S_STOP;
          duty_q  <= '0;
        end
      endcase
    end
  end

  motor_pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty_i     (duty_q),
    .force_off_i(state_q == S_DEAD),
    .pwm_o      (pwm),
    .duty_act_o (duty_act)
  );

  assign pwm_left  = pwm;
  assign pwm_right = pwm;
  assign dir_left  = dir_l_q;
  assign dir_right = dir_r_q;
  assign moving    = (duty_act != '0);
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_robot_motor_drive.sv
// Bench for robot_motor_drive: vector table, hand-written dead-time/ramp/reset
// sequences and random commands against a cycle-level behavioural model.
module tb_robot_motor_drive;

  localparam int PWM_W     = 4;
  localparam int FWD_DUTY  = 12;
  localparam int ROT_DUTY  = 8;
  localparam int RAMP_STEP = 4;
  localparam int RAMP_DIV  = 2;
  localparam int DEAD_CYC  = 3;
  localparam int PERIOD    = 16;

  localparam logic [1:0] MS_STOP = 2'd0;
  localparam logic [1:0] MS_FWD  = 2'd1;
  localparam logic [1:0] MS_ROT  = 2'd2;
  localparam logic [1:0] MS_DEAD = 2'd3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic front  = 1'b0;
  logic rotate = 1'b0;
  logic pwm_left, pwm_right, dir_left, dir_right, moving, cmd_err;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;

  robot_motor_drive #(
    .PWM_W(PWM_W), .FWD_DUTY(FWD_DUTY), .ROT_DUTY(ROT_DUTY),
    .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .front(front), .rotate(rotate),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .dir_left(dir_left), .dir_right(dir_right),
    .moving(moving), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode + cycles-in-mode + period phase
  typedef struct packed {
    logic [1:0] st;
    logic       dl;
    logic       dr;
    int         duty;
    int         since;
    int         phase;
    int         act;
    logic       fq;
    logic       rq;
    logic       err;
  } m_t;

  m_t m;

  function automatic m_t model_reset();
    m_t n;
    n.st = MS_STOP; n.dl = 1'b1; n.dr = 1'b1;
    n.duty = 0; n.since = 0; n.phase = 0; n.act = 0;
    n.fq = 1'b0; n.rq = 1'b0; n.err = 1'b0;
    return n;
  endfunction

  function automatic logic [1:0] need_dirs(input logic [1:0] c);
    return (c == MS_ROT) ? 2'b10 : 2'b11;
  endfunction

  function automatic m_t model_next(input m_t o, input logic f, input logic r);
    m_t n;
    logic [1:0] c;
    int tgt;
    n = o;
    c = (o.fq && !o.rq) ? MS_FWD : ((!o.fq && o.rq) ? MS_ROT : MS_STOP);
    n.fq = f; n.rq = r; n.err = f & r;
    n.phase = (o.phase + 1) % PERIOD;
    if (o.duty == 0) n.act = 0;
    else if (o.phase == PERIOD - 1) n.act = o.duty;
    case (o.st)
      MS_STOP: begin
        n.duty = 0;
        if (c != MS_STOP) begin
          n.since = 0;
          n.st = (need_dirs(c) == {o.dl, o.dr}) ? c : MS_DEAD;
        end
      end
      MS_DEAD: begin
        n.duty = 0;
        if (c == MS_STOP) n.st = MS_STOP;
        else begin
          n.since = o.since + 1;
          if (n.since >= DEAD_CYC) begin
            {n.dl, n.dr} = need_dirs(c);
            n.st = c;
            n.since = 0;
          end
        end
      end
      default: begin
        if (c == MS_STOP) begin
          n.st = MS_STOP; n.duty = 0;
        end else if (c != o.st) begin
          n.st = MS_DEAD; n.duty = 0; n.since = 0;
        end else begin
          n.since = o.since + 1;
          tgt = (o.st == MS_ROT) ? ROT_DUTY : FWD_DUTY;
          if (n.since % RAMP_DIV == 0)
            n.duty = (o.duty + RAMP_STEP > tgt) ? tgt : o.duty + RAMP_STEP;
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [5:0] model_outs(input m_t s);
    logic p;
    p = (s.phase < s.act) && (s.st != MS_DEAD);
    return {p, p, s.dl, s.dr, (s.act != 0), s.err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, front, rotate);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("model", {26'd0, pwm_left, pwm_right, dir_left, dir_right, moving, cmd_err},
            {26'd0, model_outs(m)});
      check("pwm_lr_equal", {31'd0, pwm_left}, {31'd0, pwm_right});
    end
  end

  typedef struct {
    logic       f;
    logic       r;
    int         n;
    logic [3:0] exp;   // {dir_left, dir_right, moving, cmd_err}
  } vec_t;

  vec_t vecs[14];
  int   ramp_exp[3];
  logic dr_exp[6];

  initial begin
    int hi;
    int q[$];
    logic [PWM_W-1:0] prev;

    vecs[0]  = '{1'b0, 1'b0,  4, 4'b1100};
    vecs[1]  = '{1'b1, 1'b0, 30, 4'b1110};
    vecs[2]  = '{1'b0, 1'b1,  3, 4'b1100};
    vecs[3]  = '{1'b0, 1'b1,  2, 4'b1000};
    vecs[4]  = '{1'b0, 1'b1, 30, 4'b1010};
    vecs[5]  = '{1'b1, 1'b1,  1, 4'b1011};
    vecs[6]  = '{1'b1, 1'b1,  1, 4'b1011};
    vecs[7]  = '{1'b0, 1'b0,  1, 4'b1000};
    vecs[8]  = '{1'b0, 1'b0,  5, 4'b1000};
    vecs[9]  = '{1'b1, 1'b0,  2, 4'b1000};
    vecs[10] = '{1'b1, 1'b0,  3, 4'b1100};
    vecs[11] = '{1'b0, 1'b0,  3, 4'b1100};
    vecs[12] = '{1'b0, 1'b1,  2, 4'b1100};
    vecs[13] = '{1'b0, 1'b0,  4, 4'b1100};
    ramp_exp = '{4, 8, 12};
    dr_exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    #2 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {26'd0, pwm_left, pwm_right, dir_left, dir_right, moving, cmd_err},
          {26'd0, 6'b001100});
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      front  = vecs[i].f;
      rotate = vecs[i].r;
      repeat (vecs[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), {28'd0, dir_left, dir_right, moving, cmd_err},
            {28'd0, vecs[i].exp});
    end

    // Soft start from stop: duty steps 4, 8, 12 and holds
    prev  = dut.duty_q;
    front = 1'b1; rotate = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dut.duty_q != prev) begin
        q.push_back(int'(dut.duty_q));
        prev = dut.duty_q;
      end
    end
    check("ramp_steps", q.size(), 3);
    for (int i = 0; i < 3 && i < q.size(); i++) check($sformatf("ramp_val%0d", i), q[i], ramp_exp[i]);
    hi = 0;
    repeat (PERIOD) begin @(negedge clk); if (pwm_left) hi++; end
    check("fwd_high_cycles", hi, FWD_DUTY);

    // Dead time with FWD/ROT toggling inside it: exit still DEAD_CYC after entry
    rotate = 1'b1; front = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin front = 1'b1; rotate = 1'b0; end
      if (i == 1) begin front = 1'b0; rotate = 1'b1; end
      check($sformatf("dead_dir_r%0d", i), {31'd0, dir_right}, {31'd0, dr_exp[i]});
      if (i >= 1) check($sformatf("dead_pwm%0d", i), {31'd0, pwm_left}, 32'd0);
    end
    repeat (40) @(negedge clk);
    hi = 0;
    repeat (PERIOD) begin @(negedge clk); if (pwm_left) hi++; end
    check("rot_high_cycles", hi, ROT_DUTY);

    // Asynchronous reset in the middle of a period
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {26'd0, pwm_left, pwm_right, dir_left, dir_right, moving, cmd_err},
             {26'd0, 6'b001100});
    front = 1'b0; rotate = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_pwm_low", {31'd0, pwm_left}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_pwm_low", {31'd0, pwm_left}, 32'd0);
    end

    // Random command stream, checked every cycle by the model
    for (int k = 0; k < 80; k++) begin
      front  = 1'($urandom_range(0, 1));
      rotate = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
